// File: rtl/pe_row_spec_if.sv
// pe_row_spec_if: operand/result bundle of a systolic PE row.
interface pe_row_spec_if #(
    parameter int BITWIDTH = 8,
    parameter int RW       = 8,
    parameter int Y_COL    = 2
);
    logic                      en;
    logic [BITWIDTH-1:0]       in_row;
    logic [Y_COL*BITWIDTH-1:0] in_col;
    logic [Y_COL*BITWIDTH-1:0] out_col;
    logic [Y_COL*RW-1:0]       row_result;
    modport master (output en, in_row, in_col, input out_col, row_result);
    modport slave  (input en, in_row, in_col, output out_col, row_result);
endinterface

// File: rtl/pe_row_spec.sv
// pe_row_spec: row of Y_COL multiply-accumulate PEs; row operand ripples right,
// column operands pass straight down with one register stage.
module pe_row_spec #(
    parameter int BITWIDTH                 = 8,
    parameter int IS_BITWIDTH_DOUBLE_SCALE = 0,
    parameter int Y_COL                    = 2
) (
    input logic          clk,
    input logic          rst_n,
    pe_row_spec_if.slave bus
);
    localparam int RW = IS_BITWIDTH_DOUBLE_SCALE != 0 ? 2*BITWIDTH : BITWIDTH;

    // The last PE's horizontal output has no consumer, so only Y_COL-1 stages are stored.
    logic [Y_COL-2:0][BITWIDTH-1:0]   h_q, h_d;
    logic [Y_COL-1:0][BITWIDTH-1:0]   a, b, oc_q, oc_d;
    logic [Y_COL-1:0][RW-1:0]         acc_q, acc_d;
    logic [Y_COL-1:0][2*BITWIDTH-1:0] prod;

    always_comb begin
        a    = {h_q, bus.in_row};
        b    = bus.in_col;
        h_d  = bus.en ? a[Y_COL-2:0] : h_q;
        oc_d = bus.en ? b : oc_q;
        prod = '0;
        acc_d = acc_q;
        for (int i = 0; i < Y_COL; i++) begin
            prod[i]  = {{BITWIDTH{1'b0}}, a[i]} * {{BITWIDTH{1'b0}}, b[i]};
            acc_d[i] = bus.en ? acc_q[i] + prod[i][RW-1:0] : acc_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            h_q   <= '0;
            oc_q  <= '0;
            acc_q <= '0;
        end else begin
            h_q   <= h_d;
            oc_q  <= oc_d;
            acc_q <= acc_d;
        end
    end

    assign bus.out_col    = oc_q;
    assign bus.row_result = acc_q;
endmodule

// File: tb/tb_pe_row_spec.sv
// tb_pe_row_spec: directed checks of reset, accumulation, pass-through, hold and wrap.
module tb_pe_row_spec;
    logic clk = 0;
    logic rst_n = 1;
    int   n_chk = 0;
    int   n_pass = 0;

    pe_row_spec_if #(.BITWIDTH(8), .RW(8),  .Y_COL(2)) bus0 ();
    pe_row_spec_if #(.BITWIDTH(8), .RW(16), .Y_COL(2)) bus1 ();

    pe_row_spec #(.BITWIDTH(8), .IS_BITWIDTH_DOUBLE_SCALE(0), .Y_COL(2))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    pe_row_spec #(.BITWIDTH(8), .IS_BITWIDTH_DOUBLE_SCALE(1), .Y_COL(2))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    assign bus1.en     = bus0.en;
    assign bus1.in_row = bus0.in_row;
    assign bus1.in_col = bus0.in_col;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] r, input logic [15:0] c);
        bus0.in_row = r;
        bus0.in_col = c;
    endtask

    logic [7:0]  acc_rows [4] = '{8'd1, 8'd2, 8'd3, 8'd0};
    logic [15:0] acc_cols [4] = '{16'h0302, 16'h0301, 16'h0008, 16'h0000};
    logic [7:0]  exp_pe0  [4] = '{8'd2, 8'd4, 8'd28, 8'd28};
    logic [7:0]  exp_pe1  [4] = '{8'd0, 8'd3, 8'd3, 8'd3};

    initial begin
        bus0.en = 1;
        drive(8'h55, 16'h1234);
        #2;
        chk("reset_async_rr", 32'(bus0.row_result), 32'h0);
        chk("reset_async_oc", 32'(bus0.out_col), 32'h0);
        tick();
        tick();
        chk("reset_hold_rr", 32'(bus0.row_result), 32'h0);
        chk("reset_hold_oc", 32'(bus0.out_col), 32'h0);
        rst_n = 0;

        for (int k = 0; k < 4; k++) begin
            drive(acc_rows[k], acc_cols[k]);
            tick();
            chk($sformatf("acc_pe0_%0d", k), 32'(bus0.row_result[7:0]), 32'(exp_pe0[k]));
            chk($sformatf("acc_pe1_%0d", k), 32'(bus0.row_result[15:8]), 32'(exp_pe1[k]));
            chk($sformatf("acc_oc_%0d", k), 32'(bus0.out_col), 32'(acc_cols[k]));
        end
        chk("acc_final", 32'(bus0.row_result), 32'h031C);

        drive(8'd7, 16'hA55A);
        tick();
        chk("pass_oc", 32'(bus0.out_col), 32'hA55A);
        chk("pass_rr", 32'(bus0.row_result), 32'h0392);

        bus0.en = 0;
        for (int k = 0; k < 5; k++) begin
            drive(8'($urandom), 16'($urandom));
            tick();
            chk($sformatf("hold_rr_%0d", k), 32'(bus0.row_result), 32'h0392);
            chk($sformatf("hold_oc_%0d", k), 32'(bus0.out_col), 32'hA55A);
        end
        bus0.en = 1;
        drive(8'd1, 16'h0101);
        tick();
        chk("resume_rr", 32'(bus0.row_result), 32'h0A93);
        chk("resume_oc", 32'(bus0.out_col), 32'h0101);

        rst_n = 1;
        #1;
        rst_n = 0;
        drive(8'hFF, 16'h00FF);
        tick();
        chk("wrap8_1", 32'(bus0.row_result[7:0]), 32'h01);
        chk("wrap16_1", 32'(bus1.row_result[15:0]), 32'hFE01);
        tick();
        chk("wrap8_2", 32'(bus0.row_result[7:0]), 32'h02);
        chk("wrap16_2", 32'(bus1.row_result[15:0]), 32'hFC02);

        rst_n = 1;
        #1;
        rst_n = 0;
        for (int k = 0; k < 2; k++) begin
            drive(acc_rows[k], acc_cols[k]);
            tick();
        end
        chk("mid_pre", 32'(bus0.row_result), 32'h0304);
        #2;
        rst_n = 1;
        #1;
        chk("mid_rst_rr", 32'(bus0.row_result), 32'h0);
        chk("mid_rst_oc", 32'(bus0.out_col), 32'h0);
        rst_n = 0;
        drive(acc_rows[0], acc_cols[0]);
        tick();
        chk("mid_restart", 32'(bus0.row_result), 32'h0002);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pe_row_spec.md
PE_ROW_SPEC -- requirements
Module: pe_row

Interface
REQ-001 Parameter BITWIDTH, default 8, width of each operand element.
REQ-002 Parameter IS_BITWIDTH_DOUBLE_SCALE, default 0; 0 gives result width RW=BITWIDTH, 1 gives RW=2*BITWIDTH.
REQ-003 Parameter Y_COL, default 2, number of processing elements (PEs) in the row.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-high (1 = reset asserted).
REQ-006 en  input  1  global enable; 1 = PEs update, 0 = all registers hold.
REQ-007 in_row  input  BITWIDTH  row operand (matrix A element) entering PE0 from the left.
REQ-008 in_col  input  Y_COL*BITWIDTH  column operands (matrix B elements); slice [i*BITWIDTH +: BITWIDTH] feeds PE i.
REQ-009 out_col  output  Y_COL*BITWIDTH  registered pass-through of in_col to the next row; slice i belongs to PE i.
REQ-010 row_result  output  Y_COL*RW  accumulators; slice [i*RW +: RW] is PE i's accumulator.

Function
REQ-011 The block SHALL instantiate Y_COL identical PEs, indexed 0..Y_COL-1 left to right.
REQ-012 Horizontal operand a_i: a_0 = in_row (combinational); a_i for i>0 = PE(i-1)'s registered horizontal output.
REQ-013 Each PE SHALL hold a horizontal register h_i; on a rising edge with en=1, h_i <= a_i, so PE i sees in_row delayed by i cycles.
REQ-014 Vertical operand b_i = in_col slice i, used combinationally by PE i; no internal skew is added (caller pre-skews).
REQ-015 On a rising edge with en=1, out_col slice i <= b_i (one-cycle latency).
REQ-016 On a rising edge with en=1, acc_i <= acc_i + a_i*b_i; the acc_i registers drive row_result directly.
REQ-017 Arithmetic SHALL be unsigned; the full product is 2*BITWIDTH bits, and the sum is truncated to the low RW bits (modulo 2^RW wrap, no saturation, no overflow flag).
REQ-018 With en=0, acc_i, h_i and out_col SHALL hold their values regardless of input activity.
REQ-019 Accumulators SHALL clear only by reset; there is no separate clear input.
REQ-020 Outputs SHALL be purely registered; there is no combinational path from inputs to out_col or row_result.

Reset
REQ-021 While rst_n=1, all acc_i, h_i and out_col SHALL be 0 immediately, without waiting for a clock edge.
REQ-022 Reset asserted mid-accumulation SHALL discard partial sums.
REQ-023 After reset release, the first rising edge with en=1 performs a normal update.
REQ-024 Reset SHALL take priority over en.

Verification
REQ-025 Reset: drive rst_n=1 with nonzero inputs and en=1 -> row_result=0 and out_col=0 asynchronously, and they stay 0 across clock edges.
REQ-026 Accumulate (BITWIDTH=8, IS_BITWIDTH_DOUBLE_SCALE=0, Y_COL=2, en=1):
- one edge each with (in_row, in_col) = (1, 0x0302), (2, 0x0301), (3, 0x0008), then (0, 0x0000);
- required: PE0 acc = 2, 4, 28, 28;
- required: PE1 acc = 0, 3, 3, 3;
- final row_result = 0x031C.
REQ-027 Pass-through: in_col=0xA55A for one edge -> out_col=0xA55A after that edge, independent of in_row.
REQ-028 Enable hold: after building nonzero sums, set en=0 and toggle inputs for 5 edges -> row_result, out_col and h_i unchanged; set en=1 -> accumulation resumes from the held values.
REQ-029 Wrap (RW=8): PE0 with in_row=0xFF, b=0xFF for two edges -> acc0 = 0x01, then 0x02. Same stimulus with IS_BITWIDTH_DOUBLE_SCALE=1 -> 0xFE01, then 0xFC02 (mod 2^16).
REQ-030 Mid-run reset: assert rst_n=1 between clock edges during REQ-026 -> all outputs 0 at once; after release, sums restart from 0.
